// File: rtl/led_fade_ramp_pkg.sv
// Shared constants for the LED fade ramp: register map, default sizes and
// the helper that locates a channel's duty byte inside duty_flat.
package led_fade_ramp_pkg;

    localparam int ADDR_STEP     = 0;
    localparam int ADDR_CH_FIRST = 1;
    localparam int DUTY_W        = 8;
    localparam int N_LED         = 7;
    localparam int ADDR_W        = 8;

    // Channel ch (1-based) occupies duty_flat[duty_msb(ch, w) -: w].
    function automatic int duty_msb(input int ch, input int w);
        return ch * w - 1;
    endfunction

endpackage

// File: rtl/led_fade_ramp_if.sv
// Register-write strobe bus from the SPI slave into the fade ramp.
interface led_fade_ramp_if #(
    parameter int DATA_W = led_fade_ramp_pkg::DUTY_W
);
    import led_fade_ramp_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              data_ready;

    modport master (output address, data, data_ready);
    modport slave  (input  address, data, data_ready);

endinterface

// File: rtl/led_fade_ramp_channel.sv
// One fade channel: target register, clamped step toward target on each
// ramp tick, and the step==0 instant-follow path.
module led_fade_ramp_channel
    import led_fade_ramp_pkg::*;
#(
    parameter int WIDTH = DUTY_W
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             tick,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] current,
    output logic             busy
);

    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_current;
    logic             r_busy;
    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_dn;
    logic [WIDTH-1:0] w_next;

    // One extra bit so overshoot past full scale or below zero is visible.
    assign w_up = {1'b0, r_current} + {1'b0, step};
    assign w_dn = {1'b0, r_current} - {1'b0, step};

    always_comb begin
        w_next = r_current;
        if (step == '0) begin
            w_next = r_target;
        end else if (tick) begin
            if (r_current < r_target) begin
                w_next = (w_up >= {1'b0, r_target}) ? r_target : w_up[WIDTH-1:0];
            end else if (r_current > r_target) begin
                w_next = (w_dn[WIDTH] || (w_dn[WIDTH-1:0] <= r_target)) ? r_target : w_dn[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_target  <= '0;
            r_current <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (wr_en) begin
                r_target <= wr_data;
            end
            r_current <= w_next;
            r_busy    <= (r_current != r_target);
        end
    end

    assign current = r_current;
    assign busy    = r_busy;

endmodule

// File: rtl/led_fade_ramp.sv
// LED fade ramp top: register decode, shared step and prescaler, and a bank
// of fade channels whose current duties feed the PWM duty inputs.
module led_fade_ramp
    import led_fade_ramp_pkg::*;
#(
    parameter int CHANNELS  = N_LED,
    parameter int WIDTH     = DUTY_W,
    parameter int PRESCALE  = 48000,
    parameter int STEP_ADDR = ADDR_STEP
)(
    input  logic                      clk,
    input  logic                      resetn,
    led_fade_ramp_if.slave            bus,
    output logic [CHANNELS*WIDTH-1:0] duty_flat,
    output logic [CHANNELS-1:0]       busy,
    output logic                      tick
);

    localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0]    r_remain;
    logic [CNT_W-1:0]    w_remain_nxt;
    logic                r_tick;
    logic [WIDTH-1:0]    r_step;
    logic                w_step_wr;
    logic [CHANNELS-1:0] w_ch_wr;
    logic [WIDTH-1:0]    w_current [CHANNELS];

    // Down-counter holding cycles left until the tick; tick is registered so
    // it lines up with the cycle the remaining count reaches zero.
    assign w_remain_nxt = (r_remain == '0) ? CNT_LAST : r_remain - 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_remain <= CNT_LAST;
            r_tick   <= 1'b0;
        end else begin
            r_remain <= w_remain_nxt;
            r_tick   <= (w_remain_nxt == '0);
        end
    end

    assign w_step_wr = bus.data_ready && (bus.address == ADDR_W'(STEP_ADDR));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_step <= WIDTH'(1);
        end else if (w_step_wr) begin
            r_step <= bus.data;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_ch_wr[g] = bus.data_ready && (bus.address == ADDR_W'(g + ADDR_CH_FIRST));

        led_fade_ramp_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .wr_en   (w_ch_wr[g]),
            .wr_data (bus.data),
            .tick    (r_tick),
            .step    (r_step),
            .current (w_current[g]),
            .busy    (busy[g])
        );

        assign duty_flat[duty_msb(g + 1, WIDTH) -: WIDTH] = w_current[g];
    end

    assign tick = r_tick;

endmodule
